// File: rtl/adb_ps2_scancode.sv
// rtl/adb_ps2_scancode.sv - ADB key events to PS/2 Set 2 byte stream
//
// Buffers ADB key events in a small FIFO. Each event is translated through a
// 128-entry keymap and sent as a PS/2 Scan Code Set 2 sequence, one byte per
// tvalid/tready handshake, into ps2_master.
//
// Optional feature macro: ADB_PS2_EXT_KEYS_EN
//   defined   : keymap entries flagged ext are sent with an E0 prefix.
//   undefined : the PREFIX state is not built. Ext entries are dropped with an
//               unmapped pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   key_byte   ADB event: bit 7 = release, bits 6:0 = keycode
//   key_valid  key_byte valid
//   key_ready  event FIFO can accept an event
//   tdata      PS/2 byte to ps2_master
//   tvalid     tdata valid
//   tready     ps2_master accepts tdata
//   unmapped   one-cycle pulse when a popped event has no Set 2 code
module adb_ps2_scancode #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_byte,
    input  logic       key_valid,
    output logic       key_ready,
    output logic [7:0] tdata,
    output logic       tvalid,
    input  logic       tready,
    output logic       unmapped
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_BREAK  = 3'd2,
`ifdef ADB_PS2_EXT_KEYS_EN
        S_PREFIX = 3'd4,
`endif
        S_CODE   = 3'd3
    } state_t;

    // Keymap result: bit 8 = ext (needs E0 prefix), bits 7:0 = Set 2 code,
    // code 00 = unmapped.
    function automatic logic [8:0] keymap(input logic [6:0] kc);
        logic [8:0] m;
        m = 9'h000;
        case (kc)
            7'h00: m = 9'h01C;  7'h01: m = 9'h01B;  7'h02: m = 9'h023;
            7'h03: m = 9'h02B;  7'h04: m = 9'h033;  7'h05: m = 9'h034;
            7'h06: m = 9'h01A;  7'h07: m = 9'h022;  7'h08: m = 9'h021;
            7'h09: m = 9'h02A;  7'h0B: m = 9'h032;  7'h0C: m = 9'h015;
            7'h0D: m = 9'h01D;  7'h0E: m = 9'h024;  7'h0F: m = 9'h02D;
            7'h10: m = 9'h035;  7'h11: m = 9'h02C;  7'h12: m = 9'h016;
            7'h13: m = 9'h01E;  7'h14: m = 9'h026;  7'h15: m = 9'h025;
            7'h16: m = 9'h036;  7'h17: m = 9'h02E;  7'h18: m = 9'h055;
            7'h19: m = 9'h046;  7'h1A: m = 9'h03D;  7'h1B: m = 9'h04E;
            7'h1C: m = 9'h03E;  7'h1D: m = 9'h045;  7'h1E: m = 9'h05B;
            7'h1F: m = 9'h044;  7'h20: m = 9'h03C;  7'h21: m = 9'h054;
            7'h22: m = 9'h043;  7'h23: m = 9'h04D;  7'h24: m = 9'h05A;
            7'h25: m = 9'h04B;  7'h26: m = 9'h03B;  7'h27: m = 9'h052;
            7'h28: m = 9'h042;  7'h29: m = 9'h04C;  7'h2A: m = 9'h05D;
            7'h2B: m = 9'h041;  7'h2C: m = 9'h04A;  7'h2D: m = 9'h031;
            7'h2E: m = 9'h03A;  7'h2F: m = 9'h049;  7'h30: m = 9'h00D;
            7'h31: m = 9'h029;  7'h32: m = 9'h00E;  7'h33: m = 9'h066;
            7'h35: m = 9'h076;  7'h36: m = 9'h014;  7'h37: m = 9'h11F;
            7'h38: m = 9'h012;  7'h39: m = 9'h058;  7'h3A: m = 9'h011;
            7'h3B: m = 9'h16B;  7'h3C: m = 9'h174;  7'h3D: m = 9'h172;
            7'h3E: m = 9'h175;  7'h4C: m = 9'h15A;  7'h7B: m = 9'h059;
            default: m = 9'h000;
        endcase
        return m;
    endfunction

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ready_en;
    logic          full, empty, push, pop;

    state_t        state_q, state_d;
    logic [7:0]    hold;
    logic [8:0]    km;
    logic          ext, release_evt, mapped;
    logic [7:0]    code;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    // ready_en keeps key_ready low throughout reset even though the FIFO is
    // already empty after the first reset edge.
    assign key_ready = ready_en && !full;
    // 8'hFF is the ADB "no key" code: handshaken but never stored.
    assign push      = key_valid && key_ready && (key_byte != 8'hFF);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hold    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (pop) begin
                hold <= mem[rd_ptr];
            end
        end
    end

    assign km          = keymap(hold[6:0]);
    assign ext         = km[8];
    assign code        = km[7:0];
    assign release_evt = hold[7];
`ifdef ADB_PS2_EXT_KEYS_EN
    assign mapped      = (code != 8'h00);
`else
    assign mapped      = (code != 8'h00) && !ext;
`endif

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        tvalid   = 1'b0;
        tdata    = 8'h00;
        unmapped = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!mapped) begin
                    unmapped = 1'b1;
                    state_d  = S_IDLE;
`ifdef ADB_PS2_EXT_KEYS_EN
                end else if (ext) begin
                    state_d = S_PREFIX;
`endif
                end else if (release_evt) begin
                    state_d = S_BREAK;
                end else begin
                    state_d = S_CODE;
                end
            end
`ifdef ADB_PS2_EXT_KEYS_EN
            S_PREFIX: begin
                tvalid = 1'b1;
                tdata  = 8'hE0;
                if (tready) begin
                    state_d = release_evt ? S_BREAK : S_CODE;
                end
            end
`endif
            S_BREAK: begin
                tvalid = 1'b1;
                tdata  = 8'hF0;
                if (tready) begin
                    state_d = S_CODE;
                end
            end
            S_CODE: begin
                tvalid = 1'b1;
                tdata  = code;
                if (tready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_adb_ps2_scancode.sv
// tb/tb_adb_ps2_scancode.sv - self-checking bench for adb_ps2_scancode
module tb_adb_ps2_scancode;
`ifdef ADB_PS2_EXT_KEYS_EN
    localparam logic EXT_EN = 1'b1;
`else
    localparam logic EXT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key_byte = 8'h00;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready = 1'b0;
    logic       unmapped;

    adb_ps2_scancode #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_byte  (key_byte),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .tdata     (tdata),
        .tvalid    (tvalid),
        .tready    (tready),
        .unmapped  (unmapped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] key;
        logic       ext;
        logic [7:0] code;
    } vec_t;

    vec_t       vt [12];
    logic [8:0] sb [$];
    int         tests = 0;
    int         failed = 0;
    int         unm_count = 0;
    logic [15:0] tv_hist = '0;
    logic       tv_seen = 1'b0;
    logic       stall_pending = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_compare(input string name, input logic [8:0] act);
        logic [8:0] exp;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL %s: got %03h but nothing expected", name, act);
        end else begin
            exp = sb.pop_front();
            chk(name, {23'd0, act}, {23'd0, exp});
        end
    endtask

    // One clock: sample at the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        tv_hist = {tv_hist[14:0], tvalid};
        if (tvalid) tv_seen = 1'b1;
        if (!rst_n) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                chk("hold_valid", {31'd0, tvalid}, 32'd1);
                chk("hold_data", {24'd0, tdata}, {24'd0, stall_data});
            end
            stall_pending = tvalid && !tready;
            stall_data    = tdata;
            if (unmapped) begin
                unm_count++;
                sb_compare("unmapped_evt", 9'h100);
            end
            if (tvalid && tready) sb_compare("ps2_byte", {1'b0, tdata});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_event(input logic [7:0] k);
        logic       ext;
        logic [7:0] code;
        ext  = 1'b0;
        code = 8'h00;
        if (k == 8'hFF) return;
        for (int i = 0; i < 12; i++) begin
            if (vt[i].key == {1'b0, k[6:0]}) begin
                ext  = vt[i].ext;
                code = vt[i].code;
            end
        end
        if (code == 8'h00 || (ext && !EXT_EN)) begin
            sb.push_back(9'h100);
        end else begin
            if (ext) sb.push_back(9'h0E0);
            if (k[7]) sb.push_back(9'h0F0);
            sb.push_back({1'b0, code});
        end
    endtask

    task automatic push_key(input logic [7:0] k);
        int guard;
        guard = 0;
        key_byte  = k;
        key_valid = 1'b1;
        while (!key_ready && guard < 100) begin
            step();
            guard++;
        end
        chk("push_wait", {31'd0, key_ready}, 32'd1);
        if (key_ready) expect_event(k);
        step();
        key_valid = 1'b0;
        key_byte  = 8'h00;
    endtask

    task automatic push_try(input logic [7:0] k, input logic exp_acc);
        key_byte  = k;
        key_valid = 1'b1;
        chk("burst_key_ready", {31'd0, key_ready}, {31'd0, exp_acc});
        if (key_ready) expect_event(k);
        step();
        key_valid = 1'b0;
        key_byte  = 8'h00;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            step();
            guard++;
        end
        repeat (6) step();
        chk("drain_left", sb.size(), 32'd0);
    endtask

    initial begin
        int u0;
        vt[0]  = '{8'h00, 1'b0, 8'h1C};
        vt[1]  = '{8'h01, 1'b0, 8'h1B};
        vt[2]  = '{8'h31, 1'b0, 8'h29};
        vt[3]  = '{8'h24, 1'b0, 8'h5A};
        vt[4]  = '{8'h35, 1'b0, 8'h76};
        vt[5]  = '{8'h38, 1'b0, 8'h12};
        vt[6]  = '{8'h3B, 1'b1, 8'h6B};
        vt[7]  = '{8'h3C, 1'b1, 8'h74};
        vt[8]  = '{8'h3D, 1'b1, 8'h72};
        vt[9]  = '{8'h3E, 1'b1, 8'h75};
        vt[10] = '{8'h4C, 1'b1, 8'h5A};
        vt[11] = '{8'h7F, 1'b0, 8'h00};

        // Reset values
        rst_n = 1'b0;
        step();
        step();
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tdata", {24'd0, tdata}, 32'd0);
        chk("rst_unmapped", {31'd0, unmapped}, 32'd0);
        chk("rst_key_ready", {31'd0, key_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_key_ready", {31'd0, key_ready}, 32'd1);

        // Press A: 1C for exactly one cycle, two cycles after the accept edge
        tready = 1'b1;
        push_key(8'h00);
        tv_hist = '0;
        repeat (4) step();
        chk("pressA_timing", {28'd0, tv_hist[3:0]}, 32'b0010);
        drain();

        // Release Return: F0, 5A back to back, then tvalid falls
        push_key(8'hA4);
        tv_hist = '0;
        repeat (5) step();
        chk("relRet_timing", {27'd0, tv_hist[4:0]}, 32'b00110);
        drain();

        // Keymap table: press and release of each mandatory entry
        for (int i = 0; i < 12; i++) begin
            push_key(vt[i].key);
            drain();
            push_key(vt[i].key | 8'h80);
            drain();
        end

        // Release Left with tready stalled before every byte
        tready  = 1'b0;
        tv_seen = 1'b0;
        u0      = unm_count;
        push_key(8'hBB);
        for (int b = 0; b < 3; b++) begin
            repeat (5) step();
            tready = 1'b1;
            step();
            tready = 1'b0;
        end
        tready = 1'b1;
        drain();
        chk("left_tvalid_seen", {31'd0, tv_seen}, {31'd0, EXT_EN});
        chk("left_unmapped", unm_count - u0, EXT_EN ? 32'd0 : 32'd1);

        // Burst overflow: 5 of 6 accepted while ps2_master stalls
        tready = 1'b0;
        push_try(8'h00, 1'b1);
        push_try(8'h01, 1'b1);
        push_try(8'h31, 1'b1);
        push_try(8'h24, 1'b1);
        push_try(8'h35, 1'b1);
        push_try(8'h38, 1'b0);
        chk("burst_queued", sb.size(), 32'd5);
        tready = 1'b1;
        drain();

        // Unmapped 7F, filtered FF, then Space
        u0 = unm_count;
        push_key(8'h7F);
        push_key(8'hFF);
        push_key(8'h31);
        drain();
        chk("filter_unmapped_pulses", unm_count - u0, 32'd1);

        // Reset in the middle of a Release Left sequence
        tready = 1'b0;
        push_key(8'hBB);
        repeat (2) step();
        tready = 1'b1;
        step();
        tready = 1'b0;
        rst_n  = 1'b0;
        step();
        sb.delete();
        chk("midrst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("midrst_tdata", {24'd0, tdata}, 32'd0);
        chk("midrst_key_ready", {31'd0, key_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("midrst_ready_back", {31'd0, key_ready}, 32'd1);
        tready = 1'b1;
        push_key(8'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/adb_ps2_scancode.md
# adb_ps2_scancode

Converts ADB keyboard key events into PS/2 Scan Code Set 2 byte sequences and streams them, one byte per handshake, into `ps2_master`. It sits directly upstream of `ps2_master`: its `tdata`/`tvalid` drive that block's data/valid inputs, and its `tready` is fed by that block's `tready` output. ADB events are buffered in a small FIFO so that key bursts from the ADB poller are not lost while PS/2 frames are being serialised.

## Interface
- `FIFO_DEPTH`, default 4: number of ADB events buffered; power of two, at least 2.
- `clk` in 1: system clock; everything is synchronous to its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `key_byte` in 8: ADB key event. Bit 7 = 1 for release, 0 for press. Bits 6:0 are the ADB keycode.
- `key_valid` in 1: `key_byte` is valid.
- `key_ready` out 1: the event FIFO can accept an event.
- `tdata` out 8: PS/2 byte to transmit.
- `tvalid` out 1: `tdata` is valid.
- `tready` in 1: `ps2_master` accepts `tdata` this cycle.
- `unmapped` out 1: one-cycle pulse when a popped event has no Set 2 mapping and is dropped.

## Operation
- **Push.** An event is pushed into the FIFO on a rising edge where `key_valid && key_ready`.
  - `key_ready = !full`. It does not depend on a same-cycle pop.
  - `key_byte == 8'hFF` (ADB "no key") is accepted but not written into the FIFO.
- **Keymap.** A combinational 128-entry keymap maps an ADB keycode to {ext, code[7:0]}. code = 00 means unmapped. The entries below are mandatory:
  - A 0x00 -> 1C
  - S 0x01 -> 1B
  - Space 0x31 -> 29
  - Return 0x24 -> 5A
  - Esc 0x35 -> 76
  - L-Shift 0x38 -> 12
  - Left 0x3B -> ext 6B
  - Right 0x3C -> ext 74
  - Down 0x3D -> ext 72
  - Up 0x3E -> ext 75
  - Keypad Enter 0x4C -> ext 5A
  - Power 0x7F -> unmapped
  - The remaining entries follow the team keymap document.
- **FSM states.** IDLE, LOOKUP, PREFIX, BREAK, CODE.
- **IDLE.** If the FIFO is non-empty: pop the head event into a holding register, then go to LOOKUP.
- **LOOKUP.** Keymap result is available.
  - Unmapped: pulse `unmapped` and go to IDLE.
  - Mapped with ext: go to PREFIX (`tdata` = E0).
  - Mapped, not ext, release: go to BREAK (`tdata` = F0).
  - Mapped, not ext, press: go to CODE (`tdata` = code).
  - `tvalid` rises on entry to PREFIX, BREAK or CODE.
- **Byte states.** PREFIX, BREAK and CODE each hold `tvalid=1` with stable `tdata` until `tvalid && tready`. On that handshake:
  - PREFIX goes to BREAK if the event is a release, otherwise to CODE.
  - BREAK goes to CODE.
  - CODE goes to IDLE with `tvalid=0`.
- **Byte sequences.**
  - Press: [E0] code.
  - Release: [E0] F0 code.
- **Ordering.** Bytes of one event are never interleaved with another event. Events are emitted in FIFO order.
- **Reset.** `rst_n` low at a rising edge abandons any sequence in progress with no partial completion: FIFO emptied, FSM to IDLE.

## Timing
- **Reset values:**
  - `tvalid` = 0
  - `tdata` = 8'h00
  - `unmapped` = 0
  - `key_ready` = 0 while `rst_n` is low, 1 from the first edge after release.
- **Latency.** For an event pushed at edge k into an empty FIFO with the FSM in IDLE:
  - Popped at edge k+1.
  - LOOKUP during cycle k+1 to k+2.
  - `tvalid` high after edge k+2.
- **Between bytes.** No bubble. The next byte is presented in the cycle after the accepting edge.
- **Between events.** After the CODE handshake, `tvalid` is low for at least 2 cycles (IDLE, then LOOKUP).
- **Unmapped events.** An unmapped event occupies 2 cycles and never asserts `tvalid`. `unmapped` is high for exactly the LOOKUP cycle.
- **`tready` without `tvalid`.** Ignored.
- **FIFO simultaneous push and pop.** Both take effect.
  - When full: the pop happens, but the push was refused because `key_ready` was 0.
  - When empty: the FIFO does not bypass. The event is popped one cycle later.

## Configuration
- Macro: `ADB_PS2_EXT_KEYS_EN`.
- **Defined:** ext entries emit the E0 prefix as described in Operation.
- **Undefined:**
  - PREFIX state is not built.
  - Keymap entries with ext = 1 are treated as unmapped: dropped with an `unmapped` pulse.
  - Non-ext behaviour and timing are identical in both builds.

## Test plan
- **Press A.** `key_byte` 00, `tready` held 1 -> `tdata` 1C with `tvalid` high for exactly 1 cycle, starting 2 cycles after the accept edge.
- **Release Return.** `key_byte` A4, `tready` 1 -> bytes F0, 5A on consecutive cycles; `tvalid` then falls.
- **Release Left, `tready` stalls.** `key_byte` BB, `tready` low for 5 cycles before each byte -> E0, F0, 6B, each held stable while stalled. In the EXT-disabled build: no `tvalid`, one `unmapped` pulse.
- **Burst overflow.** 6 pushes (00, 01, 31, 24, 35, 38) with `tready` 0 -> `key_ready` falls after 4 pushes are buffered (1 popped into the holding register), so exactly 5 events are accepted. Then `tready` 1 -> 1C, 1B, 29, 5A, 76 in order.
- **Filtered and unmapped events.** Push 7F, then FF, then 31 -> one `unmapped` pulse, FF not queued, then 29 output.
- **Reset mid-sequence.** Push BB, accept E0, assert `rst_n` low for 1 cycle -> `tvalid` 0, `tdata` 00, FIFO empty; a subsequent press of 00 yields 1C only.
